stream_burst_ctrl: RTL and testbench
====================================

Name: stream_burst_ctrl

Overview:
Output-stream sequencer for the result path of the multi-core accelerator. It collects per-core completion pulses into jobs and queues completed jobs. For each job it emits a burst of read-enable/address pulses to the result buffer (stream_v/stream_a) and the matching AXI-Stream-style dst_valid/dst_last, one cycle later. Successor of the single-beat, single-core stream controller: it adds a variable core count, a runtime burst length, an address counter and a job queue.

Parameters:
CORE_NUM, 4, number of cores reporting completion
AW, 8, width of stream_a and burst_len
PEND_W, 4, width of the pending-job counter (max 2^PEND_W-1 queued jobs)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
get_fin  in  CORE_NUM  per-core one-cycle completion pulse
core_mask  in  CORE_NUM  cores participating in a job; static while busy
burst_len  in  AW  beats per burst minus one; sampled at burst start
dst_ready  in  1  downstream ready; low stalls the whole output pipeline
dst_valid  out  1  output beat valid (registered)
dst_last  out  1  last beat of burst (registered)
stream_v  out  1  result-buffer read enable (combinational)
stream_a  out  AW  result-buffer read address (registered counter)
busy  out  1  any fin collected, job pending or burst running
pend_ovf  out  1  sticky: a job was dropped because the queue was full

Behaviour:
- Reset: all registers clear. dst_valid=0, dst_last=0, stream_a=0, pend_ovf=0. State=IDLE, fin_seen=0, pend=0. A reset mid-burst aborts the burst; no dst_last is emitted.
- Fin collection:
  - fin_seen[k] sets on get_fin[k]&core_mask[k].
  - job_done = (core_mask!=0) & (((fin_seen|get_fin)&core_mask)==core_mask).
  - On job_done, fin_seen clears in the same cycle; get_fin bits in that cycle are consumed.
  - Pulses from unmasked cores are ignored. Repeated pulses from a core before job_done are idempotent.
- Pending counter pend (PEND_W bits):
  - +1 on job_done; -1 on burst start.
  - Both in the same cycle: unchanged.
  - job_done at pend=max with no simultaneous start: job is dropped, pend stays at max, pend_ovf=1 until rst.
- FSM:
  - IDLE: if pend!=0 & dst_ready, go to RUN. Latch len=burst_len, set stream_a=0, decrement pend. A job_done in that same cycle is counted as above.
  - RUN: stream_v = dst_ready. On stream_v, if stream_a==len go to IDLE, else stream_a += 1. When dst_ready=0, state and address hold.
  - RUN always returns to IDLE, giving exactly one idle cycle between back-to-back bursts.
  - stream_a holds its last value in IDLE. burst_len changes during RUN are ignored.
- stream_v = (state==RUN) & dst_ready. It is never asserted in IDLE.
- Output pipeline (1-cycle latency, matching the buffer read latency):
  - When dst_ready=1: dst_valid <= (state==RUN); dst_last <= (state==RUN) & (stream_a==len).
  - When dst_ready=0: both hold.
  - The beat issued with stream_a=n appears on dst_valid in the next dst_ready=1 cycle.
- burst_len=0: single-beat burst; dst_valid and dst_last are asserted together.
- Beat count per burst is exactly len+1. No wrap: len <= 2^AW-1, so stream_a never overflows.
- busy = (fin_seen!=0) | (pend!=0) | (state==RUN).

Test Plan:
1. CORE_NUM=4, core_mask=4'hF, get_fin bits at cycles 2,5,5,9, burst_len=3, dst_ready=1 -> job_done at cycle 9, start at cycle 10; stream_v 11..14 with stream_a 0,1,2,3; dst_valid 12..15, dst_last only at 15; busy falls after 15.
2. Same job with dst_ready low for 2 cycles at the second beat -> stream_a holds at 1, dst_valid/dst_last hold; 4 beats total, dst_last on the 4th accepted beat.
3. Two job_done events before the first start, burst_len=2 -> pend reaches 2; two 3-beat bursts separated by exactly one IDLE cycle; pend steps 2->1->0.
4. burst_len=0, core_mask=4'b0010, get_fin=4'b0011 -> one beat with dst_valid=dst_last=1 in the same cycle; bit0 ignored, fin_seen ends at 0.
5. PEND_W=2, dst_ready=0, 4 job_done events -> pend=3, pend_ovf=1 after the 4th. After dst_ready=1, exactly 3 bursts; pend_ovf stays 1 until rst.
6. rst asserted during beat 2 of a 4-beat burst -> next cycle dst_valid=0, dst_last=0, stream_a=0, busy=0; no dst_last observed; a new job then streams normally from address 0.

Source files
------------

// File: rtl/stream_burst_ctrl.sv
// stream_burst_ctrl
//
// Output-stream sequencer for the accelerator result path. It gathers
// per-core completion pulses into jobs and counts completed jobs in a small
// pending counter. For each job it walks the result buffer with a burst of
// read-enable/address pulses (stream_v/stream_a). The matching
// dst_valid/dst_last beat is presented one cycle later, which lines up with
// the buffer read latency.
//
// Handshake: dst_ready is a stall, not a per-beat accept. While dst_ready is
// low, the whole output pipeline freezes. That covers the FSM, the address
// counter and the dst_valid/dst_last registers. A beat issued on stream_v
// reaches dst_valid in the next cycle. It is taken by the first following
// cycle in which dst_ready is high.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   get_fin     per-core one-cycle completion pulse
//   core_mask   cores participating in a job (static while busy)
//   burst_len   beats per burst minus one, sampled when a burst starts
//   dst_ready   downstream ready / pipeline enable
//   dst_valid   registered output beat valid
//   dst_last    registered last-beat flag
//   stream_v    result-buffer read enable (combinational)
//   stream_a    result-buffer read address (registered counter)
//   busy        fins collected, jobs pending or burst running
//   pend_ovf    sticky: a completed job was dropped on a full queue
//   state_dbg   FSM state (0 = IDLE, 1 = RUN)
//   pend_dbg    pending-job counter

module stream_burst_ctrl #(
    parameter int CORE_NUM = 4,
    parameter int AW       = 8,
    parameter int PEND_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CORE_NUM-1:0] get_fin,
    input  logic [CORE_NUM-1:0] core_mask,
    input  logic [AW-1:0]       burst_len,
    input  logic                dst_ready,
    output logic                dst_valid,
    output logic                dst_last,
    output logic                stream_v,
    output logic [AW-1:0]       stream_a,
    output logic                busy,
    output logic                pend_ovf,
    output logic                state_dbg,
    output logic [PEND_W-1:0]   pend_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [AW-1:0]     ADDR_ONE = AW'(1);

    state_t              state;
    logic [CORE_NUM-1:0] fin_seen;
    logic [CORE_NUM-1:0] fin_hit;
    logic [PEND_W-1:0]   pend;
    logic [AW-1:0]       len;
    logic                job_done;
    logic                start;
    logic                at_end;

    // A job completes once every masked core has reported. A pulse arriving
    // in the completing cycle counts directly and is not stored.
    assign fin_hit  = (fin_seen | get_fin) & core_mask;
    assign job_done = (core_mask != '0) && (fin_hit == core_mask);
    assign start    = (state == IDLE) && (pend != '0) && dst_ready;
    assign at_end   = (stream_a == len);

    assign stream_v  = (state == RUN) && dst_ready;
    assign busy      = (fin_seen != '0) || (pend != '0) || (state == RUN);
    assign state_dbg = state;
    assign pend_dbg  = pend;

    // Completion collection and the pending-job queue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_seen <= '0;
            pend     <= '0;
            pend_ovf <= 1'b0;
        end else begin
            fin_seen <= job_done ? '0 : fin_hit;
            case ({job_done, start})
                2'b10: begin
                    // A full queue drops the job rather than wrapping the count.
                    if (pend == PEND_MAX) pend_ovf <= 1'b1;
                    else                  pend     <= pend + PEND_ONE;
                end
                2'b01:   pend <= pend - PEND_ONE;
                default: ;
            endcase
        end
    end

    // Burst FSM with its registered outputs. RUN always falls back to IDLE,
    // so back-to-back bursts are separated by exactly one idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            stream_a  <= '0;
            dst_valid <= 1'b0;
            dst_last  <= 1'b0;
        end else begin
            if (dst_ready) begin
                dst_valid <= (state == RUN);
                dst_last  <= (state == RUN) && at_end;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        len      <= burst_len;
                        stream_a <= '0;
                    end
                end
                RUN: begin
                    if (dst_ready) begin
                        if (at_end) state    <= IDLE;
                        else        stream_a <= stream_a + ADDR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_burst_ctrl.sv
// Testbench for stream_burst_ctrl (CORE_NUM=4, AW=8, PEND_W=2 so the queue
// fills quickly). The opening burst comes from a table of per-cycle records.
// Hand-written sequences cover stalls, queued jobs, single-beat bursts,
// overflow and mid-burst reset. Randomized traffic runs against a reference
// model built from the job/burst rules. A last-flag scoreboard follows every
// accepted beat.

module tb_stream_burst_ctrl;

    localparam int CN   = 4;
    localparam int AW   = 8;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CN-1:0] get_fin   = '0;
    logic [CN-1:0] core_mask = '0;
    logic [AW-1:0] burst_len = '0;
    logic          dst_ready = 1'b0;
    logic          dst_valid, dst_last, stream_v, busy, pend_ovf, state_dbg;
    logic [AW-1:0] stream_a;
    logic [PW-1:0] pend_dbg;

    stream_burst_ctrl #(.CORE_NUM(CN), .AW(AW), .PEND_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .get_fin   (get_fin),
        .core_mask (core_mask),
        .burst_len (burst_len),
        .dst_ready (dst_ready),
        .dst_valid (dst_valid),
        .dst_last  (dst_last),
        .stream_v  (stream_v),
        .stream_a  (stream_a),
        .busy      (busy),
        .pend_ovf  (pend_ovf),
        .state_dbg (state_dbg),
        .pend_dbg  (pend_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Jobs are counted as an integer queue depth. A burst is a running flag,
    // the current beat address and the latched length. The output stage
    // remembers the last beat issued while ready was high.
    logic [CN-1:0] m_fin;
    int            m_pend, m_addr, m_len;
    bit            m_ovf, m_run, m_dv, m_dl;
    logic [0:0]    exp_q[$];
    int            acc_beats, acc_last, last_idx, vl_same;

    task automatic model_clear();
        m_fin = '0; m_pend = 0; m_addr = 0; m_len = 0;
        m_ovf = 0; m_run = 0; m_dv = 0; m_dl = 0;
        exp_q.delete();
    endtask

    function automatic bit m_busy();
        return (m_fin != '0) || (m_pend != 0) || m_run;
    endfunction

    task automatic model_check();
        chk("stream_v", stream_v, m_run && dst_ready);
        chk("stream_a", stream_a, m_addr);
        chk("dst_valid", dst_valid, m_dv);
        chk("dst_last", dst_last, m_dl);
        chk("busy", busy, m_busy());
        chk("pend_ovf", pend_ovf, m_ovf);
        chk("state", state_dbg, m_run);
        chk("pend", pend_dbg, m_pend);
        if (dst_valid === 1'b1 && dst_ready === 1'b1) begin
            acc_beats++;
            if (dst_last === 1'b1) begin
                acc_last++;
                last_idx = acc_beats;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got beat expected none (cycle %0d)", cyc);
            end else begin
                chk("sb_last", dst_last, exp_q.pop_front());
            end
        end
        if (dst_valid === 1'b1 && dst_last === 1'b1) vl_same++;
    endtask

    task automatic model_step();
        logic [CN-1:0] seen;
        bit done, st;
        if (!rst && m_run && dst_ready) exp_q.push_back(m_addr == m_len);
        if (rst) begin
            model_clear();
            return;
        end
        seen = (m_fin | get_fin) & core_mask;
        done = (core_mask != '0) && (seen == core_mask);
        st   = !m_run && (m_pend > 0) && dst_ready;
        if (dst_ready) begin
            m_dv = m_run;
            m_dl = m_run && (m_addr == m_len);
        end
        if (st) begin
            m_run  = 1;
            m_len  = int'(burst_len);
            m_addr = 0;
        end else if (m_run && dst_ready) begin
            if (m_addr == m_len) m_run = 0;
            else                 m_addr++;
        end
        m_pend = m_pend + int'(done) - int'(st);
        if (m_pend > PMAX) begin
            m_pend = PMAX;
            m_ovf  = 1;
        end
        m_fin = done ? '0 : seen;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [CN-1:0] f, input logic [CN-1:0] m,
                         input logic [AW-1:0] l, input logic r, input logic rs);
        get_fin = f; core_mask = m; burst_len = l; dst_ready = r; rst = rs;
    endtask

    task automatic tick(input logic [CN-1:0] f, input logic [CN-1:0] m,
                        input logic [AW-1:0] l, input logic r, input logic rs);
        drive(f, m, l, r, rs);
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick('0, 4'hF, '0, 1'b1, 1'b1);
        tick('0, 4'hF, '0, 1'b1, 1'b1);
        acc_beats = 0; acc_last = 0; last_idx = 0; vl_same = 0;
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [CN-1:0] fin;
        logic          sv;
        logic [AW-1:0] sa;
        logic          dv;
        logic          dl;
        logic          bsy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [CN-1:0] rmask;
        model_clear();
        acc_beats = 0; acc_last = 0; last_idx = 0; vl_same = 0;

        // power-up reset
        drive('0, 4'hF, 8'd3, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dst_valid", dst_valid, 0);
        chk("rst_dst_last", dst_last, 0);
        chk("rst_stream_a", stream_a, 0);
        chk("rst_pend_ovf", pend_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_pend", pend_dbg, 0);
        model_step();
        @(posedge clk);
        #1;

        // Test 1: mask F, fins at cycles 2,5,5,9, burst_len 3, ready high.
        //              fin   sv    sa    dv    dl    busy
        tbl[0]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'h1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{4'h6, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4'h8, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{4'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{4'h0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{4'h0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{4'h0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{4'h0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{4'h0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{4'h0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].fin, 4'hF, 8'd3, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("t1_sv[%0d]", i), stream_v, tbl[i].sv);
            chk($sformatf("t1_sa[%0d]", i), stream_a, tbl[i].sa);
            chk($sformatf("t1_dv[%0d]", i), dst_valid, tbl[i].dv);
            chk($sformatf("t1_dl[%0d]", i), dst_last, tbl[i].dl);
            chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].bsy);
            model_step();
            @(posedge clk);
            #1;
        end

        // Test 2: stall two cycles while the second beat (address 1) is up.
        do_reset();
        tick(4'hF, 4'hF, 8'd3, 1'b1, 1'b0);
        tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        chk("t2_stall_addr", stream_a, 1);
        tick(4'h0, 4'hF, 8'd3, 1'b0, 1'b0);
        tick(4'h0, 4'hF, 8'd3, 1'b0, 1'b0);
        repeat (6) tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        chk("t2_beats", acc_beats, 4);
        chk("t2_last_cnt", acc_last, 1);
        chk("t2_last_idx", last_idx, 4);

        // Test 3: two jobs queued before the first start, burst_len 2.
        do_reset();
        tick(4'hF, 4'hF, 8'd2, 1'b0, 1'b0);
        tick(4'hF, 4'hF, 8'd2, 1'b0, 1'b0);
        chk("t3_pend2", pend_dbg, 2);
        repeat (10) tick(4'h0, 4'hF, 8'd2, 1'b1, 1'b0);
        chk("t3_beats", acc_beats, 6);
        chk("t3_bursts", acc_last, 2);
        chk("t3_pend0", pend_dbg, 0);

        // Test 4: single-beat burst from core 1 only; core 0 pulse ignored.
        do_reset();
        tick(4'b0011, 4'b0010, 8'd0, 1'b1, 1'b0);
        repeat (5) tick(4'h0, 4'b0010, 8'd0, 1'b1, 1'b0);
        chk("t4_beats", acc_beats, 1);
        chk("t4_valid_last_same", vl_same, 1);
        chk("t4_busy_end", busy, 0);

        // Test 5: four jobs with ready low overflow a 3-deep queue.
        do_reset();
        repeat (4) tick(4'hF, 4'hF, 8'd1, 1'b0, 1'b0);
        chk("t5_pend_max", pend_dbg, PMAX);
        chk("t5_ovf", pend_ovf, 1);
        repeat (12) tick(4'h0, 4'hF, 8'd1, 1'b1, 1'b0);
        chk("t5_bursts", acc_last, 3);
        chk("t5_beats", acc_beats, 6);
        chk("t5_ovf_sticky", pend_ovf, 1);
        do_reset();
        chk("t5_ovf_cleared", pend_ovf, 0);

        // Test 6: reset during beat 2 of a 4-beat burst, then a fresh job.
        do_reset();
        tick(4'hF, 4'hF, 8'd3, 1'b1, 1'b0);
        tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b1);
        drive(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        #1;
        chk("t6_dv", dst_valid, 0);
        chk("t6_dl", dst_last, 0);
        chk("t6_sa", stream_a, 0);
        chk("t6_busy", busy, 0);
        chk("t6_no_last", acc_last, 0);
        tick(4'hF, 4'hF, 8'd3, 1'b1, 1'b0);
        repeat (7) tick(4'h0, 4'hF, 8'd3, 1'b1, 1'b0);
        chk("t6_new_last", acc_last, 1);

        // Randomized traffic against the model; mask changes only when idle.
        do_reset();
        rmask = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            if (!m_busy() && $urandom_range(0, 7) == 0)
                rmask = CN'($urandom_range(0, 15));
            tick(($urandom_range(0, 2) == 0) ? CN'($urandom_range(0, 15)) : '0,
                 rmask, AW'($urandom_range(0, 4)),
                 ($urandom_range(0, 3) != 0), 1'b0);
        end
        repeat (40) tick('0, rmask, 8'd2, 1'b1, 1'b0);
        chk("rand_sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
